mem_access_stage: RTL and testbench

Pipeline MEM stage of the five-stage CPU: takes the EX/MEM register fields, performs the data-memory load/store over a req/ack bus, and owns the MEM/WB pipeline register. Store data comes from EX/MEM Rt data or, when the MEM-stage forward unit sets `i_forward`, from this block's own `o_MEM_WB_mem_data`. The block stalls the upstream pipeline while an access is outstanding and latches the forwarded store data at issue, because MEM/WB takes bubbles during a stall.

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/mem_access_stage_if.sv | 33 +++
 rtl/mem_wb_reg.sv | 53 +++++
 rtl/mem_access_stage.sv | 175 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// cpu_pkg
//   Shared definitions for the CPU pipeline stages: default data/register
//   widths, the MEM-stage access state enum and the MEM/WB control bundle
//   together with its bubble value.
//   No ports (package).
package cpu_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 6;

  // Memory-access sequencer states.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Control bits carried by the MEM/WB register.
  typedef struct packed {
    logic valid;
    logic reg_write;
    logic mem_to_reg;
    logic mem_read;
  } wb_ctrl_t;

  // A bubble retires nothing: no valid, no register write, no load select.
  localparam wb_ctrl_t WB_CTRL_BUBBLE = '0;

endpackage

// File: rtl/mem_access_stage_if.sv
// mem_access_stage_if
//   Data-memory request/acknowledge bus between the MEM stage and memory.
//   req   : access request, held until ack
//   we    : 1 = store, 0 = load
//   addr  : word-aligned byte address
//   wdata : store data
//   ack   : access completes this cycle
//   rdata : load data, valid with ack
//   Modports: master (MEM stage side), slave (memory side).
interface mem_access_stage_if
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) ();

  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (
    output req, we, addr, wdata,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output ack, rdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// mem_wb_reg
//   MEM/WB pipeline register. Loads every clock edge; the selects decide
//   what is loaded.
//   clk, rst        : clock, asynchronous active-high reset
//   sel_bubble      : load an all-zero bubble
//   sel_load_data   : mem_data takes load_data_in (otherwise 0)
//   kill_reg_write  : force reg_write to 0 (dropped/failed access)
//   ctrl_in, write_reg_in, alu_out_in, load_data_in : EX/MEM side fields
//   ctrl, write_reg, alu_out, mem_data              : registered outputs
module mem_wb_reg
  import cpu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_bubble,
  input  logic              sel_load_data,
  input  logic              kill_reg_write,
  input  wb_ctrl_t          ctrl_in,
  input  logic [REG_W-1:0]  write_reg_in,
  input  logic [DATA_W-1:0] alu_out_in,
  input  logic [DATA_W-1:0] load_data_in,
  output wb_ctrl_t          ctrl,
  output logic [REG_W-1:0]  write_reg,
  output logic [DATA_W-1:0] alu_out,
  output logic [DATA_W-1:0] mem_data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl      <= WB_CTRL_BUBBLE;
      write_reg <= '0;
      alu_out   <= '0;
      mem_data  <= '0;
    end else if (sel_bubble) begin
      ctrl      <= WB_CTRL_BUBBLE;
      write_reg <= '0;
      alu_out   <= '0;
      mem_data  <= '0;
    end else begin
      ctrl.valid      <= ctrl_in.valid;
      ctrl.reg_write  <= ctrl_in.reg_write & ~kill_reg_write;
      ctrl.mem_to_reg <= ctrl_in.mem_to_reg;
      ctrl.mem_read   <= ctrl_in.mem_read;
      write_reg       <= write_reg_in;
      alu_out         <= alu_out_in;
      mem_data        <= sel_load_data ? load_data_in : '0;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage
//   MEM stage of the five-stage pipeline. Issues data-memory loads/stores
//   over a req/ack bus, stalls upstream while an access is outstanding,
//   times out hung accesses and owns the MEM/WB pipeline register.
//   i_clk, i_reset      : clock, asynchronous active-high reset
//   i_EX_MEM_*          : EX/MEM register fields (held by o_stall)
//   i_forward           : use o_MEM_WB_mem_data as store data
//   dmem                : data-memory bus (master side)
//   o_stall             : freeze PC, IF/ID, ID/EX, EX/MEM
//   o_MEM_WB_*          : MEM/WB register outputs
//   o_misalign          : pulse, misaligned memory op dropped
//   o_bus_err           : pulse, access timed out
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int REG_W   = DEF_REG_W,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_EX_MEM_valid,
  input  logic [DATA_W-1:0] i_EX_MEM_alu_out,
  input  logic [DATA_W-1:0] i_EX_MEM_rt_data,
  input  logic [REG_W-1:0]  i_EX_MEM_write_reg,
  input  logic              i_EX_MEM_mem_read,
  input  logic              i_EX_MEM_mem_write,
  input  logic              i_EX_MEM_reg_write,
  input  logic              i_EX_MEM_mem_to_reg,
  input  logic              i_forward,
  mem_access_stage_if.master dmem,
  output logic              o_stall,
  output logic              o_MEM_WB_valid,
  output logic              o_MEM_WB_reg_write,
  output logic              o_MEM_WB_mem_to_reg,
  output logic              o_MEM_WB_mem_read,
  output logic [REG_W-1:0]  o_MEM_WB_write_reg,
  output logic [DATA_W-1:0] o_MEM_WB_alu_out,
  output logic [DATA_W-1:0] o_MEM_WB_mem_data,
  output logic              o_misalign,
  output logic              o_bus_err
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic              req_reg;
  logic              we_reg;
  logic [DATA_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;

  logic mem_op, aligned, idle_mem, start, misalign, busy, ack_done, timeout_hit;
  logic wb_bubble, wb_load_data, wb_kill;
  wb_ctrl_t ctrl_in, wb_ctrl;

  // ---------------- decode ----------------
  assign mem_op      = i_EX_MEM_mem_read | i_EX_MEM_mem_write;
  assign aligned     = (i_EX_MEM_alu_out[1:0] == 2'b00);
  assign idle_mem    = (state_reg == IDLE) & i_EX_MEM_valid & mem_op;
  assign start       = idle_mem & aligned;
  assign misalign    = idle_mem & ~aligned;
  assign busy        = (state_reg == BUSY);
  assign ack_done    = busy & dmem.ack;
  // Ack in the final allowed cycle completes normally instead of erroring.
  assign timeout_hit = busy & ~dmem.ack & (cnt_reg == CNT_W'(TIMEOUT - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state_reg <= IDLE;
    else         state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = BUSY;
      BUSY:    if (ack_done || timeout_hit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // Gated by reset so every output reads 0 while reset is asserted, even
  // though EX/MEM may still present a memory op.
  always_comb begin
    o_stall      = 1'b0;
    o_misalign   = 1'b0;
    o_bus_err    = 1'b0;
    wb_bubble    = 1'b1;
    wb_load_data = 1'b0;
    wb_kill      = 1'b0;
    if (!i_reset) begin
      case (state_reg)
        IDLE: begin
          o_stall    = start;
          o_misalign = misalign;
          wb_bubble  = ~i_EX_MEM_valid | start;
          wb_kill    = misalign;
        end
        BUSY: begin
          // Releasing the stall on ack lets the next memory op issue at once.
          o_stall      = ~(ack_done | timeout_hit);
          o_bus_err    = timeout_hit;
          wb_bubble    = ~(ack_done | timeout_hit);
          wb_load_data = ack_done & ~i_EX_MEM_mem_write;
          wb_kill      = timeout_hit;
        end
        default: ;
      endcase
    end
  end

  // ---------------- bus latches and wait counter ----------------
  // Store data is captured at issue: MEM/WB turns into bubbles during the
  // stall, so a forwarded value would otherwise be lost.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      req_reg   <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
    end else if (start) begin
      req_reg   <= 1'b1;
      we_reg    <= i_EX_MEM_mem_write;
      addr_reg  <= i_EX_MEM_alu_out;
      wdata_reg <= i_forward ? o_MEM_WB_mem_data : i_EX_MEM_rt_data;
      cnt_reg   <= '0;
    end else if (ack_done || timeout_hit) begin
      req_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (busy) begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  assign dmem.req   = req_reg;
  assign dmem.we    = we_reg;
  assign dmem.addr  = addr_reg;
  assign dmem.wdata = wdata_reg;

  // ---------------- MEM/WB register ----------------
  assign ctrl_in.valid      = i_EX_MEM_valid;
  assign ctrl_in.reg_write  = i_EX_MEM_reg_write;
  assign ctrl_in.mem_to_reg = i_EX_MEM_mem_to_reg;
  assign ctrl_in.mem_read   = i_EX_MEM_mem_read;

  mem_wb_reg #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_mem_wb (
    .clk            (i_clk),
    .rst            (i_reset),
    .sel_bubble     (wb_bubble),
    .sel_load_data  (wb_load_data),
    .kill_reg_write (wb_kill),
    .ctrl_in        (ctrl_in),
    .write_reg_in   (i_EX_MEM_write_reg),
    .alu_out_in     (i_EX_MEM_alu_out),
    .load_data_in   (dmem.rdata),
    .ctrl           (wb_ctrl),
    .write_reg      (o_MEM_WB_write_reg),
    .alu_out        (o_MEM_WB_alu_out),
    .mem_data       (o_MEM_WB_mem_data)
  );

  assign o_MEM_WB_valid      = wb_ctrl.valid;
  assign o_MEM_WB_reg_write  = wb_ctrl.reg_write;
  assign o_MEM_WB_mem_to_reg = wb_ctrl.mem_to_reg;
  assign o_MEM_WB_mem_read   = wb_ctrl.mem_read;

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage
//   Self-checking bench: a vector table for single-cycle instructions,
//   hand sequences for multi-cycle memory accesses, and a scoreboard of
//   expected MEM/WB retirements checked whenever MEM/WB holds a valid entry.
module tb_mem_access_stage;
  import cpu_pkg::*;

  localparam int DW = 32;
  localparam int RW = 6;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          ex_valid;
  logic [DW-1:0] ex_alu, ex_rt;
  logic [RW-1:0] ex_wr;
  logic          ex_mr, ex_mw, ex_rw, ex_m2r, fwd;
  logic          ack;
  logic [DW-1:0] rdata;

  logic          stall, wb_valid, wb_rw, wb_m2r, wb_mr, misalign, bus_err;
  logic [RW-1:0] wb_wr;
  logic [DW-1:0] wb_alu, wb_data;

  always #5 clk = ~clk;

  mem_access_stage_if #(.DATA_W(DW)) dmem ();
  assign dmem.ack   = ack;
  assign dmem.rdata = rdata;

  mem_access_stage #(.DATA_W(DW), .REG_W(RW), .TIMEOUT(TO)) dut (
    .i_clk               (clk),
    .i_reset             (rst),
    .i_EX_MEM_valid      (ex_valid),
    .i_EX_MEM_alu_out    (ex_alu),
    .i_EX_MEM_rt_data    (ex_rt),
    .i_EX_MEM_write_reg  (ex_wr),
    .i_EX_MEM_mem_read   (ex_mr),
    .i_EX_MEM_mem_write  (ex_mw),
    .i_EX_MEM_reg_write  (ex_rw),
    .i_EX_MEM_mem_to_reg (ex_m2r),
    .i_forward           (fwd),
    .dmem                (dmem),
    .o_stall             (stall),
    .o_MEM_WB_valid      (wb_valid),
    .o_MEM_WB_reg_write  (wb_rw),
    .o_MEM_WB_mem_to_reg (wb_m2r),
    .o_MEM_WB_mem_read   (wb_mr),
    .o_MEM_WB_write_reg  (wb_wr),
    .o_MEM_WB_alu_out    (wb_alu),
    .o_MEM_WB_mem_data   (wb_data),
    .o_misalign          (misalign),
    .o_bus_err           (bus_err)
  );

  typedef struct {
    logic          valid, rw, m2r, mr;
    logic [RW-1:0] wr;
    logic [DW-1:0] alu, data;
  } wb_t;

  typedef struct {
    logic          v;
    logic [DW-1:0] alu;
    logic [RW-1:0] wr;
    logic          mr, mw, rw, m2r;
    logic          exp_mis;
  } vec_t;

  wb_t  exp_q[$];
  vec_t vecs[7];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Scoreboard: each cycle MEM/WB holds a valid entry is one retirement.
  always @(negedge clk) begin
    wb_t e;
    if (!rst && wb_valid) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL wb_retire: got wr=%0d alu=%h data=%h, expected no retirement",
                 wb_wr, wb_alu, wb_data);
      end else begin
        e = exp_q.pop_front();
        if ({wb_rw, wb_m2r, wb_mr, wb_wr, wb_alu, wb_data} !==
            {e.rw, e.m2r, e.mr, e.wr, e.alu, e.data}) begin
          n_miss++;
          $display("FAIL wb_retire: got rw=%b m2r=%b mr=%b wr=%0d alu=%h data=%h, expected rw=%b m2r=%b mr=%b wr=%0d alu=%h data=%h",
                   wb_rw, wb_m2r, wb_mr, wb_wr, wb_alu, wb_data,
                   e.rw, e.m2r, e.mr, e.wr, e.alu, e.data);
        end else begin
          $display("ok   wb_retire: wr=%0d alu=%h data=%h rw=%b", wb_wr, wb_alu, wb_data, wb_rw);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [DW-1:0] alu, input logic [DW-1:0] rt,
                       input logic [RW-1:0] wr, input logic mr, input logic mw,
                       input logic rw, input logic m2r, input logic f);
    ex_valid = v;  ex_alu = alu; ex_rt = rt; ex_wr = wr;
    ex_mr = mr;    ex_mw = mw;   ex_rw = rw; ex_m2r = m2r; fwd = f;
  endtask

  task automatic nop();
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One memory op from issue to completion. ack_at = BUSY cycle index of
  // the ack (1 = first BUSY cycle), 0 = never ack (timeout expected).
  task automatic run_mem(input string name, input logic [DW-1:0] addr, input logic [DW-1:0] rt,
                         input logic [RW-1:0] wr, input logic is_store, input logic f,
                         input int ack_at, input logic [DW-1:0] rd, input logic [DW-1:0] exp_wdata);
    wb_t e;
    int  last;
    last = (ack_at > 0) ? ack_at : TO;
    drive(1'b1, addr, rt, wr, ~is_store, is_store, ~is_store, ~is_store, f);
    e.valid = 1'b1;
    e.m2r   = ~is_store;
    e.mr    = ~is_store;
    e.wr    = wr;
    e.alu   = addr;
    e.rw    = (ack_at > 0) ? ~is_store : 1'b0;
    e.data  = (ack_at > 0 && !is_store) ? rd : '0;
    exp_q.push_back(e);
    ack = 1'b0;
    for (int k = 0; k <= last; k++) begin
      if (k > 0) begin
        ack   = (k == ack_at);
        rdata = (k == ack_at) ? rd : 32'h0BAD_0BAD;
      end
      @(negedge clk);
      check($sformatf("%s stall c%0d", name, k), stall, (k < last));
      check($sformatf("%s req c%0d", name, k), dmem.req, (k >= 1));
      check($sformatf("%s bus_err c%0d", name, k), bus_err, (ack_at == 0 && k == last));
      if (k >= 1) begin
        check($sformatf("%s addr c%0d", name, k), dmem.addr, addr);
        check($sformatf("%s wdata c%0d", name, k), dmem.wdata, exp_wdata);
        check($sformatf("%s we c%0d", name, k), dmem.we, is_store);
      end
      tick();
    end
    ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_t e;
    rst = 1'b1; ack = 1'b0; rdata = '0;
    nop();
    vecs[0] = '{1'b1, 32'h0000_0010,  6'd5,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // ADD r5
    vecs[1] = '{1'b1, 32'hFFFF_FFFF,  6'd63, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0}; // ALU, odd result
    vecs[2] = '{1'b1, 32'h0000_0102,  6'd2,  1'b0, 1'b1, 1'b1, 1'b0, 1'b1}; // SW misaligned
    vecs[3] = '{1'b1, 32'h0000_0101,  6'd4,  1'b1, 1'b0, 1'b1, 1'b1, 1'b1}; // LW misaligned
    vecs[4] = '{1'b0, 32'h0000_0020,  6'd8,  1'b1, 1'b0, 1'b1, 1'b1, 1'b0}; // invalid LW
    vecs[5] = '{1'b0, 32'h0000_0023,  6'd9,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0}; // invalid, misaligned SW
    vecs[6] = '{1'b1, 32'h0000_0000,  6'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0}; // no-write ALU op

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset stall", stall, 1'b0);
    check("reset req", dmem.req, 1'b0);
    check("reset wb_valid", wb_valid, 1'b0);
    check("reset wb_alu", wb_alu, '0);
    check("reset wb_data", wb_data, '0);
    check("reset misalign", misalign, 1'b0);
    tick();
    rst = 1'b0;

    // Single-cycle instructions from the table.
    for (int i = 0; i < 7; i++) begin
      drive(vecs[i].v, vecs[i].alu, 32'h5555_0000, vecs[i].wr,
            vecs[i].mr, vecs[i].mw, vecs[i].rw, vecs[i].m2r, 1'b0);
      if (vecs[i].v) begin
        e.valid = 1'b1;
        e.rw    = vecs[i].rw & ~vecs[i].exp_mis;
        e.m2r   = vecs[i].m2r;
        e.mr    = vecs[i].mr;
        e.wr    = vecs[i].wr;
        e.alu   = vecs[i].alu;
        e.data  = '0;
        exp_q.push_back(e);
      end
      @(negedge clk);
      check($sformatf("vec%0d stall", i), stall, 1'b0);
      check($sformatf("vec%0d misalign", i), misalign, vecs[i].exp_mis);
      check($sformatf("vec%0d req", i), dmem.req, 1'b0);
      tick();
    end
    nop();
    @(negedge clk);
    check("after vecs req", dmem.req, 1'b0);
    tick();

    // LW with ack on the 3rd BUSY cycle.
    run_mem("lw100", 32'h100, 32'h7777_7777, 6'd7, 1'b0, 1'b0, 3, 32'hDEAD_BEEF, 32'h7777_7777);
    nop();
    @(negedge clk);
    check("lw100 req after ack", dmem.req, 1'b0);
    tick();

    // LW r3 then SW r3 back-to-back with store data forwarded from MEM/WB.
    run_mem("lw_r3", 32'h200, 32'h1111_1111, 6'd3, 1'b0, 1'b0, 1, 32'hCAFE_0001, 32'h1111_1111);
    run_mem("sw_fwd", 32'h204, 32'h0, 6'd3, 1'b1, 1'b1, 3, 32'h0, 32'hCAFE_0001);
    nop();
    tick();

    // No ack: bus error in the TO-th BUSY cycle, then an ordinary op proves IDLE.
    run_mem("lw_to", 32'h300, 32'h0, 6'd9, 1'b0, 1'b0, 0, 32'h0, 32'h0);
    drive(1'b1, 32'h44, 32'h0, 6'd10, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    e = '{1'b1, 1'b1, 1'b0, 1'b0, 6'd10, 32'h44, 32'h0};
    exp_q.push_back(e);
    @(negedge clk);
    check("post_to stall", stall, 1'b0);
    tick();

    // Ack in the same cycle the timeout would fire: ack wins.
    run_mem("lw_edge", 32'h304, 32'h0, 6'd11, 1'b0, 1'b0, TO, 32'h1234_5678, 32'h0);
    nop();
    tick();

    // Reset in the 2nd BUSY cycle of a load; the load never retires.
    drive(1'b1, 32'h400, 32'h0, 6'd12, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("rst_busy req", dmem.req, 1'b0);
    check("rst_busy stall", stall, 1'b0);
    check("rst_busy wb_valid", wb_valid, 1'b0);
    check("rst_busy wb_rw", wb_rw, 1'b0);
    check("rst_busy wb_data", wb_data, '0);
    tick();
    nop();
    rst = 1'b0;
    ack = 1'b1;
    rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    check("idle_ack req", dmem.req, 1'b0);
    check("idle_ack stall", stall, 1'b0);
    check("idle_ack bus_err", bus_err, 1'b0);
    tick();
    ack = 1'b0;
    @(negedge clk);
    check("idle_ack wb_valid", wb_valid, 1'b0);
    check("idle_ack wb_data", wb_data, '0);
    tick();

    repeat (2) tick();
    check("scoreboard drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
